// File: rtl/unsigned_alu_pkg.sv
// unsigned_alu_pkg
//   Shared definitions for unsigned_pipe_alu and its sequential divider:
//   opcode encodings, control FSM state type and compare result values.
//   Optional divider build is selected with the UNSIGNED_ALU_DIV_EN macro
//   (see unsigned_pipe_alu.sv).
package unsigned_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_NAND = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_XNOR = 4'b1001;
    localparam logic [3:0] OP_EQ   = 4'b1010;
    localparam logic [3:0] OP_GT   = 4'b1011;
    localparam logic [3:0] OP_LT   = 4'b1100;
    localparam logic [3:0] OP_SHR  = 4'b1101;
    localparam logic [3:0] OP_SHL  = 4'b1110;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int CMP_EQ_VAL = 1;
    localparam int CMP_GT_VAL = 2;
    localparam int CMP_LT_VAL = 3;

endpackage

// File: rtl/unsigned_pipe_alu_seq_divider.sv
// seq_divider
//   Restoring unsigned divider, one quotient bit per clock, WIDTH iterations.
//   Only built when UNSIGNED_ALU_DIV_EN is defined.
//   Ports:
//     clk, rst        clock, synchronous active-high reset (aborts a divide)
//     start           latch dividend/divisor and begin (divisor must be non-zero)
//     dividend        unsigned dividend
//     divisor         unsigned divisor
//     done            high during the final iteration cycle
//     quotient        final quotient, valid while done is high
//     remainder       final remainder, valid while done is high
`ifdef UNSIGNED_ALU_DIV_EN
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);

    logic             busy_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] div_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             unused_trial_msb;

    // The quotient register doubles as the dividend shift register: each
    // step moves its MSB into the partial remainder and a quotient bit in.
    // Since the remainder stays below the divisor, a successful trial
    // subtraction always fits in WIDTH bits, so the trial MSB is dropped.
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        fits     = (shifted >= {1'b0, div_q});
        trial    = shifted - {1'b0, div_q};
        rem_next = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next = {quo_q[WIDTH-2:0], fits};
    end

    assign unused_trial_msb = trial[WIDTH];

    // Final values are presented combinationally so the parent can capture
    // them on the same edge that completes the last iteration.
    assign done      = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign quotient  = quo_next;
    assign remainder = rem_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= dividend;
            div_q  <= divisor;
        end else if (busy_q) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            if (done) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule
`endif

// File: rtl/unsigned_pipe_alu.sv
// unsigned_pipe_alu
//   Registered unsigned ALU with valid/ready input, multi-cycle divider,
//   multiply high half, carry/borrow and divide-by-zero status.
//   Build option: define UNSIGNED_ALU_DIV_EN to build the sequential divider;
//   without it opcode DIV completes in one cycle with OUT=0, HI=0, DIV0_ERR=1.
//   Ports:
//     CLK, RST                  clock, synchronous active-high reset
//     IN_VALID / IN_READY       input handshake
//     A, B, ALU_FUN             operands and opcode
//     OUT_VALID                 one-cycle pulse when result registers update
//     ALU_OUT, ALU_OUT_HI       primary result, high half / remainder
//     Arith/Logic/CMP/Shift_Flag  op-class flags
//     CARRY, DIV0_ERR           carry/borrow, divide-by-zero
//     fsm_state                 control FSM state (debug)
//
//   Handshake: an operation transfers on a rising edge where IN_VALID and
//   IN_READY are both high; IN_READY is high exactly in IDLE and depends
//   only on state, never on IN_VALID. While not ready, IN_VALID is ignored.
module unsigned_pipe_alu
    import unsigned_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_FUN,
    output logic             OUT_VALID,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic [WIDTH-1:0] ALU_OUT_HI,
    output logic             Arith_Flag,
    output logic             Logic_Flag,
    output logic             CMP_Flag,
    output logic             Shift_Flag,
    output logic             CARRY,
    output logic             DIV0_ERR,
    output state_t           fsm_state
);

    localparam int SHW = $clog2(WIDTH);

    state_t state_q, state_d;
    logic   load_single;
    logic   load_div;
    logic   div_start;

    logic [2*WIDTH-1:0] product;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [SHW-1:0]     shamt;

    logic [WIDTH-1:0] res_lo, res_hi;
    logic             res_arith, res_logic, res_cmp, res_shift;
    logic             res_carry, res_div0;

    assign product = A * B;
    assign sum     = {1'b0, A} + {1'b0, B};
    // Top bit of the extended difference is the borrow (A < B).
    assign diff    = {1'b0, A} - {1'b0, B};
    assign shamt   = B[SHW-1:0];

    // Single-cycle datapath
    always_comb begin
        res_lo    = '0;
        res_hi    = '0;
        res_arith = 1'b0;
        res_logic = 1'b0;
        res_cmp   = 1'b0;
        res_shift = 1'b0;
        res_carry = 1'b0;
        res_div0  = 1'b0;
        case (ALU_FUN)
            OP_ADD: begin
                res_lo    = sum[WIDTH-1:0];
                res_carry = sum[WIDTH];
                res_arith = 1'b1;
            end
            OP_SUB: begin
                res_lo    = diff[WIDTH-1:0];
                res_carry = diff[WIDTH];
                res_arith = 1'b1;
            end
            OP_MUL: begin
                {res_hi, res_lo} = product;
                res_arith        = 1'b1;
            end
            OP_DIV: begin
                // Non-zero divisors go to the sequential divider; this path
                // only produces the divide-by-zero (or no-divider) result.
                res_arith = 1'b1;
                res_div0  = 1'b1;
`ifdef UNSIGNED_ALU_DIV_EN
                res_lo    = '1;
                res_hi    = A;
`endif
            end
            OP_AND:  begin res_lo = A & B;    res_logic = 1'b1; end
            OP_OR:   begin res_lo = A | B;    res_logic = 1'b1; end
            OP_NAND: begin res_lo = ~(A & B); res_logic = 1'b1; end
            OP_NOR:  begin res_lo = ~(A | B); res_logic = 1'b1; end
            OP_XOR:  begin res_lo = A ^ B;    res_logic = 1'b1; end
            OP_XNOR: begin res_lo = ~(A ^ B); res_logic = 1'b1; end
            OP_EQ: begin
                res_lo  = (A == B) ? WIDTH'(CMP_EQ_VAL) : '0;
                res_cmp = 1'b1;
            end
            OP_GT: begin
                res_lo  = (A > B) ? WIDTH'(CMP_GT_VAL) : '0;
                res_cmp = 1'b1;
            end
            OP_LT: begin
                res_lo  = (A < B) ? WIDTH'(CMP_LT_VAL) : '0;
                res_cmp = 1'b1;
            end
            OP_SHR: begin res_lo = A >> shamt; res_shift = 1'b1; end
            OP_SHL: begin res_lo = A << shamt; res_shift = 1'b1; end
            default: ;
        endcase
    end

`ifdef UNSIGNED_ALU_DIV_EN
    logic             div_done;
    logic [WIDTH-1:0] div_quotient;
    logic [WIDTH-1:0] div_remainder;

    seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (CLK),
        .rst       (RST),
        .start     (div_start),
        .dividend  (A),
        .divisor   (B),
        .done      (div_done),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );
`endif

    // Control FSM
    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        IN_READY    = 1'b0;
        load_single = 1'b0;
        load_div    = 1'b0;
        div_start   = 1'b0;
        case (state_q)
            IDLE: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
`ifdef UNSIGNED_ALU_DIV_EN
                    if (ALU_FUN == OP_DIV && B != '0) begin
                        div_start = 1'b1;
                        state_d   = BUSY;
                    end else begin
                        load_single = 1'b1;
                    end
`else
                    load_single = 1'b1;
`endif
                end
            end
            BUSY: begin
`ifdef UNSIGNED_ALU_DIV_EN
                if (div_done) begin
                    load_div = 1'b1;
                    state_d  = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign fsm_state = state_q;

    // Result registers: updated only alongside OUT_VALID, hold otherwise.
    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT_VALID  <= 1'b0;
            ALU_OUT    <= '0;
            ALU_OUT_HI <= '0;
            Arith_Flag <= 1'b0;
            Logic_Flag <= 1'b0;
            CMP_Flag   <= 1'b0;
            Shift_Flag <= 1'b0;
            CARRY      <= 1'b0;
            DIV0_ERR   <= 1'b0;
        end else begin
            OUT_VALID <= load_single | load_div;
            if (load_single) begin
                ALU_OUT    <= res_lo;
                ALU_OUT_HI <= res_hi;
                Arith_Flag <= res_arith;
                Logic_Flag <= res_logic;
                CMP_Flag   <= res_cmp;
                Shift_Flag <= res_shift;
                CARRY      <= res_carry;
                DIV0_ERR   <= res_div0;
            end
`ifdef UNSIGNED_ALU_DIV_EN
            else if (load_div) begin
                ALU_OUT    <= div_quotient;
                ALU_OUT_HI <= div_remainder;
                Arith_Flag <= 1'b1;
                Logic_Flag <= 1'b0;
                CMP_Flag   <= 1'b0;
                Shift_Flag <= 1'b0;
                CARRY      <= 1'b0;
                DIV0_ERR   <= 1'b0;
            end
`endif
        end
    end

endmodule
